// File: rtl/video_timing_if.sv
// video_timing_if: CPU register-window bus for video_timing.
//
// Protocol: there is no valid/ready pair. The master presents cs/rw/addr/di
// for one clock; a write (cs=1, rw=0) commits at that rising edge. A read
// (cs=1, rw=1) returns dout combinationally in the same cycle. dout is 0
// whenever cs=0, so several slaves can be ORed together.
//
// Signals:
//   cs    master->slave  register select
//   rw    master->slave  1 = read, 0 = write
//   addr  master->slave  register index (2 bits)
//   di    master->slave  write data (8 bits)
//   dout  slave->master  read data (8 bits)
interface video_timing_if;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] di;
  logic [7:0] dout;

  modport master (output cs, rw, addr, di, input dout);
  modport slave  (input cs, rw, addr, di, output dout);
endinterface

// File: rtl/video_timing.sv
// video_timing: raster timing generator, video output stage and a small
// register window (raster-line interrupt, frame counter, vblank status).
//
// Optional feature macro: VIDEO_TIMING_RASTER_IRQ_EN
//   defined   -> LINE compare, pending, irq_en and irq are present.
//   undefined -> irq tied low, CTRL bits 0-1 read 0, compare logic removed.
//
// Ports:
//   clk, reset          single pixel clock, synchronous active-low reset
//   hsync, vsync        registered raster syncs to the chip (active-high)
//   hpos, vpos          hcount[7:0], vcount[6:0]
//   rgb_in              pixel colour returned by the chip PIPE clocks later
//   vid_rgb/hs/vs/de    blanked, aligned display outputs
//   bus                 CPU register window (video_timing_if.slave)
//   irq                 raster interrupt, level, active-high
//
// Register map: 0 LINE (wr line_cmp / rd vcount[7:0]), 1 CTRL
// (bit0 irq_en, bit1 pending w1c, bit2 vblank), 2 FRAME (rd only), 3 zero.
module video_timing #(
  parameter int H_ACTIVE = 160,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 16,
  parameter int H_BP     = 16,
  parameter int V_ACTIVE = 120,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 13,
  parameter int PIPE     = 1,
  parameter int RGB      = 16
) (
  input  logic           clk,
  input  logic           reset,
  output logic           hsync,
  output logic           vsync,
  output logic [7:0]     hpos,
  output logic [6:0]     vpos,
  input  logic [RGB-1:0] rgb_in,
  output logic [RGB-1:0] vid_rgb,
  output logic           vid_hs,
  output logic           vid_vs,
  output logic           vid_de,
  video_timing_if.slave  bus,
  output logic           irq
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [8:0] HT_LAST  = 9'(HT - 1);
  localparam logic [8:0] VT_LAST  = 9'(VT - 1);
  localparam logic [8:0] H_ACT    = 9'(H_ACTIVE);
  localparam logic [8:0] V_ACT    = 9'(V_ACTIVE);
  localparam logic [8:0] HS_START = 9'(H_ACTIVE + H_FP);
  localparam logic [8:0] HS_END   = 9'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [8:0] VS_START = 9'(V_ACTIVE + V_FP);
  localparam logic [8:0] VS_END   = 9'(V_ACTIVE + V_FP + V_SYNC);

  // ---------------------------------------------------------------------
  // Raster counters and sync decode
  // ---------------------------------------------------------------------
  logic [8:0] hcount_q, hcount_d;
  logic [8:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic       frame_wrap;

  always_comb begin
    hcount_d   = hcount_q + 9'd1;
    vcount_d   = vcount_q;
    frame_wrap = 1'b0;
    if (hcount_q == HT_LAST) begin
      hcount_d = 9'd0;
      if (vcount_q == VT_LAST) begin
        vcount_d   = 9'd0;
        frame_wrap = 1'b1;
      end else begin
        vcount_d = vcount_q + 9'd1;
      end
    end
  end

  // Decoding the next counter values makes the registered syncs line up
  // with the counters they describe.
  always_comb begin
    hsync_d = (hcount_d >= HS_START) && (hcount_d < HS_END);
    vsync_d = (vcount_d >= VS_START) && (vcount_d < VS_END);
    de_d    = (hcount_d < H_ACT) && (vcount_d < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hcount_q <= 9'd0;
      vcount_q <= 9'd0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      // Pixel (0,0) is visible, so de must already be high in the first
      // cycle after release.
      de_q     <= 1'b1;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign hpos  = hcount_q[7:0];
  assign vpos  = vcount_q[6:0];

  // ---------------------------------------------------------------------
  // Output stage: PIPE-deep delay matching the chip's pixel latency,
  // then one output register that also blanks the colour.
  // ---------------------------------------------------------------------
  logic [PIPE-1:0] de_pipe_q;
  logic [PIPE-1:0] hs_pipe_q;
  logic [PIPE-1:0] vs_pipe_q;
  logic [RGB-1:0]  vid_rgb_q;
  logic            vid_hs_q;
  logic            vid_vs_q;
  logic            vid_de_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      de_pipe_q <= '0;
      hs_pipe_q <= '0;
      vs_pipe_q <= '0;
    end else begin
      de_pipe_q[0] <= de_q;
      hs_pipe_q[0] <= hsync_q;
      vs_pipe_q[0] <= vsync_q;
      for (int i = 1; i < PIPE; i++) begin
        de_pipe_q[i] <= de_pipe_q[i-1];
        hs_pipe_q[i] <= hs_pipe_q[i-1];
        vs_pipe_q[i] <= vs_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vid_rgb_q <= '0;
      vid_hs_q  <= 1'b0;
      vid_vs_q  <= 1'b0;
      vid_de_q  <= 1'b0;
    end else begin
      vid_rgb_q <= de_pipe_q[PIPE-1] ? rgb_in : '0;
      vid_hs_q  <= hs_pipe_q[PIPE-1];
      vid_vs_q  <= vs_pipe_q[PIPE-1];
      vid_de_q  <= de_pipe_q[PIPE-1];
    end
  end

  assign vid_rgb = vid_rgb_q;
  assign vid_hs  = vid_hs_q;
  assign vid_vs  = vid_vs_q;
  assign vid_de  = vid_de_q;

  // ---------------------------------------------------------------------
  // Frame counter and vblank status
  // ---------------------------------------------------------------------
  logic [7:0] frame_q;
  logic       vblank;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame_q <= 8'd0;
    end else if (frame_wrap) begin
      frame_q <= frame_q + 8'd1;
    end
  end

  assign vblank = (vcount_q >= V_ACT);

  // ---------------------------------------------------------------------
  // Raster-line interrupt
  // ---------------------------------------------------------------------
  logic [7:0] ctrl_rd;

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  logic [7:0] line_cmp_q, line_cmp_d;
  logic       irq_en_q, irq_en_d;
  logic       pending_q, pending_d;
  logic       wr_line, wr_ctrl, line_hit;

  assign wr_line = bus.cs && !bus.rw && (bus.addr == 2'd0);
  assign wr_ctrl = bus.cs && !bus.rw && (bus.addr == 2'd1);

  // Fires only on the edge that moves the counters to the start of the
  // matching line; a compare value >= VT never matches a legal vcount.
  assign line_hit = (hcount_d == 9'd0) && (vcount_d == {1'b0, line_cmp_q});

  always_comb begin
    line_cmp_d = line_cmp_q;
    irq_en_d   = irq_en_q;
    pending_d  = pending_q;
    if (wr_line) begin
      line_cmp_d = bus.di;
    end
    if (wr_ctrl) begin
      irq_en_d = bus.di[0];
      if (bus.di[1]) begin
        pending_d = 1'b0;
      end
    end
    // A simultaneous hit beats the write-1-clear.
    if (line_hit) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      line_cmp_q <= 8'd0;
      irq_en_q   <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      line_cmp_q <= line_cmp_d;
      irq_en_q   <= irq_en_d;
      pending_q  <= pending_d;
    end
  end

  assign irq     = pending_q && irq_en_q;
  assign ctrl_rd = {5'd0, vblank, pending_q, irq_en_q};
`else
  logic unused_bus;
  assign unused_bus = ^{bus.di, bus.rw};
  assign irq        = 1'b0;
  assign ctrl_rd    = {5'd0, vblank, 2'b00};
`endif

  // ---------------------------------------------------------------------
  // Read mux (combinational, zero when not selected)
  // ---------------------------------------------------------------------
  always_comb begin
    bus.dout = 8'd0;
    if (bus.cs) begin
      case (bus.addr)
        2'd0:    bus.dout = vcount_q[7:0];
        2'd1:    bus.dout = ctrl_rd;
        2'd2:    bus.dout = frame_q;
        default: bus.dout = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_video_timing.sv
module tb_video_timing;
  localparam int H_ACTIVE = 160;
  localparam int H_FP     = 8;
  localparam int H_SYNC   = 16;
  localparam int H_BP     = 16;
  localparam int V_ACTIVE = 120;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 4;
  localparam int V_BP     = 13;
  localparam int PIPE     = 1;
  localparam int RGB      = 16;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FT = HT * VT;

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  typedef struct packed {
    logic           hsync;
    logic           vsync;
    logic [7:0]     hpos;
    logic [6:0]     vpos;
    logic           vid_de;
    logic           vid_hs;
    logic           vid_vs;
    logic [RGB-1:0] vid_rgb;
    logic           irq;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           hsync, vsync, vid_hs, vid_vs, vid_de, irq;
  logic [7:0]     hpos;
  logic [6:0]     vpos;
  logic [RGB-1:0] rgb_in, vid_rgb;

  always #5 clk = ~clk;

  video_timing_if bus ();

  video_timing dut (
    .clk    (clk),
    .reset  (reset),
    .hsync  (hsync),
    .vsync  (vsync),
    .hpos   (hpos),
    .vpos   (vpos),
    .rgb_in (rgb_in),
    .vid_rgb(vid_rgb),
    .vid_hs (vid_hs),
    .vid_vs (vid_vs),
    .vid_de (vid_de),
    .bus    (bus),
    .irq    (irq)
  );

  // ---------------- reference model state ----------------
  int             vectors = 0;
  int             miscompares = 0;
  int             t;            // cycles since reset release
  logic           m_pending;
  logic           m_irq_en;
  logic [7:0]     m_line;
  logic [RGB-1:0] last_rgb;     // rgb_in driven in the previous cycle

  function automatic logic in_range(int v, int lo, int n);
    return (v >= lo) && (v < lo + n);
  endfunction

  // Expected raster/video outputs for cycle tt, from pixel arithmetic.
  function automatic obs_t model_obs(int tt);
    obs_t o;
    int x, y, s, sx, sy;
    logic de;
    o = '0;
    x = tt % HT;
    y = (tt / HT) % VT;
    o.hsync = in_range(x, H_ACTIVE + H_FP, H_SYNC);
    o.vsync = in_range(y, V_ACTIVE + V_FP, V_SYNC);
    o.hpos  = 8'(x);
    o.vpos  = 7'(y);
    s = tt - PIPE - 1;
    if (s >= 0) begin
      sx = s % HT;
      sy = (s / HT) % VT;
      de = (sx < H_ACTIVE) && (sy < V_ACTIVE);
      o.vid_de  = de;
      o.vid_hs  = in_range(sx, H_ACTIVE + H_FP, H_SYNC);
      o.vid_vs  = in_range(sy, V_ACTIVE + V_FP, V_SYNC);
      o.vid_rgb = de ? last_rgb : '0;
    end
    o.irq = m_pending && m_irq_en;
    return o;
  endfunction

  function automatic logic [7:0] model_dout(int tt);
    int y;
    y = (tt / HT) % VT;
    if (!bus.cs) return 8'd0;
    case (bus.addr)
      2'd0:    return 8'(y);
      2'd1:    return {5'd0, (y >= V_ACTIVE), m_pending, m_irq_en};
      2'd2:    return 8'((tt / FT) % 256);
      default: return 8'd0;
    endcase
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.hsync = hsync;   o.vsync = vsync;
    o.hpos = hpos;     o.vpos = vpos;
    o.vid_de = vid_de; o.vid_hs = vid_hs; o.vid_vs = vid_vs;
    o.vid_rgb = vid_rgb;
    o.irq = irq;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_bus(input logic cs, input logic rw,
                         input logic [1:0] a, input logic [7:0] d);
    bus.cs = cs; bus.rw = rw; bus.addr = a; bus.di = d;
  endtask

  task automatic rand_read();
    set_bus($urandom_range(0, 3) != 0, 1'b1, 2'($urandom_range(0, 3)), 8'($urandom));
  endtask

  task automatic rand_access();
    set_bus($urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
            2'($urandom_range(0, 3)), 8'($urandom));
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    t         = 0;
    m_pending = 1'b0;
    m_irq_en  = 1'b0;
    m_line    = 8'd0;
    last_rgb  = '0;
    rgb_in    = RGB'($urandom);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    set_bus(1'b0, 1'b1, 2'd0, 8'd0);
    repeat (n) @(posedge clk);
    release_reset();
  endtask

  // Close out the current cycle: apply the bus write to the model, advance
  // to the next cycle, then apply the line-start event.
  task automatic tick();
    logic [7:0] old_line;
    logic       wr;
    old_line = m_line;
    wr = bus.cs && !bus.rw;
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    if (wr && bus.addr == 2'd0) m_line = bus.di;
    if (wr && bus.addr == 2'd1) begin
      m_irq_en = bus.di[0];
      if (bus.di[1]) m_pending = 1'b0;
    end
`endif
    last_rgb = rgb_in;
    @(posedge clk);
    #1;
    t++;
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    if ((t % HT == 0) && ((t / HT) % VT == int'(old_line))) m_pending = 1'b1;
`else
    if (wr && old_line != 8'd0) m_pending = 1'b0;
`endif
    rgb_in = RGB'($urandom);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t zero_obs;
    obs_t act;
    zero_obs = '0;
    reset  = 1'b0;
    rgb_in = RGB'($urandom);
    set_bus(1'b0, 1'b1, 2'd0, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    act = dut_obs();
    vectors++;
    if (act !== zero_obs) begin
      miscompares++;
      $display("FAIL reset_outputs got %h exp %h", act, zero_obs);
    end
    for (int a = 0; a < 4; a++) begin
      set_bus(1'b1, 1'b1, 2'(a), 8'd0);
      #1;
      vectors++;
      if (bus.dout !== 8'd0) begin
        miscompares++;
        $display("FAIL reset_reg%0d got %h exp 00", a, bus.dout);
      end
    end
    set_bus(1'b0, 1'b1, 2'd2, 8'd0);
    release_reset();
    @(negedge clk);
    act = dut_obs();
    vectors++;
    if (act !== model_obs(t)) begin
      miscompares++;
      $display("FAIL first_pixel got %h exp %h", act, model_obs(t));
    end
  endtask

  task automatic test_raster_frame();
    obs_t act, exp;
    logic [7:0] exp_d;
    int hs_cnt, vs_first, de_cnt;
    hs_cnt = 0; vs_first = -1; de_cnt = 0;
    do_reset(3);
    while (t <= FT + 10) begin
      if (t == FT) set_bus(1'b1, 1'b1, 2'd2, 8'd0);
      else rand_access();
      @(negedge clk);
      act = dut_obs();
      exp = model_obs(t);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL raster t=%0d got %h exp %h", t, act, exp);
      end
      exp_d = model_dout(t);
      vectors++;
      if (bus.dout !== exp_d) begin
        miscompares++;
        $display("FAIL regread t=%0d addr=%0d got %h exp %h", t, bus.addr, bus.dout, exp_d);
      end
      if (t == FT) begin
        vectors++;
        if (bus.dout !== 8'd1) begin
          miscompares++;
          $display("FAIL frame_count t=%0d got %h exp 01", t, bus.dout);
        end
      end
      if (t < HT && hsync === 1'b1) hs_cnt++;
      if (vs_first < 0 && vsync === 1'b1) vs_first = t;
      if (t >= PIPE + 1 && t < FT + PIPE + 1 && vid_de === 1'b1) de_cnt++;
      tick();
    end
    vectors++;
    if (hs_cnt != H_SYNC) begin
      miscompares++;
      $display("FAIL hsync_width got %0d exp %0d", hs_cnt, H_SYNC);
    end
    vectors++;
    if (vs_first != (V_ACTIVE + V_FP) * HT) begin
      miscompares++;
      $display("FAIL vsync_start got %0d exp %0d", vs_first, (V_ACTIVE + V_FP) * HT);
    end
    vectors++;
    if (de_cnt != H_ACTIVE * V_ACTIVE) begin
      miscompares++;
      $display("FAIL de_count got %0d exp %0d", de_cnt, H_ACTIVE * V_ACTIVE);
    end
  endtask

  // Ends in cycle 40080 (x=80, y=60 of frame 1) with pending set.
  task automatic test_line_irq();
    obs_t act, exp;
    logic [7:0] exp_d;
    do_reset(2);
    while (1) begin
      case (t)
        0:       set_bus(1'b1, 1'b0, 2'd0, 8'd50);
        1:       set_bus(1'b1, 1'b0, 2'd1, 8'h01);
        10050:   set_bus(1'b1, 1'b0, 2'd1, 8'h02);
        10060:   set_bus(1'b1, 1'b0, 2'd1, 8'h00);
        37999:   set_bus(1'b1, 1'b0, 2'd1, 8'h02);
        38000:   set_bus(1'b1, 1'b1, 2'd1, 8'h00);
        38100:   set_bus(1'b1, 1'b0, 2'd1, 8'h01);
        default: rand_read();
      endcase
      @(negedge clk);
      act = dut_obs();
      exp = model_obs(t);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL irq_raster t=%0d got %h exp %h", t, act, exp);
      end
      exp_d = model_dout(t);
      vectors++;
      if (bus.dout !== exp_d) begin
        miscompares++;
        $display("FAIL irq_regread t=%0d addr=%0d got %h exp %h", t, bus.addr, bus.dout, exp_d);
      end
      if (t == 10000 || t == 40080) begin
        vectors++;
        if (irq !== IRQ_ON || vpos !== 7'(t / HT % VT)) begin
          miscompares++;
          $display("FAIL irq_rise t=%0d got irq=%b vpos=%0d exp irq=%b", t, irq, vpos, IRQ_ON);
        end
      end
      if (t == 10051 || t == 38000) begin
        vectors++;
        if (irq !== 1'b0) begin
          miscompares++;
          $display("FAIL irq_low t=%0d got %b exp 0", t, irq);
        end
      end
      if (t == 38000) begin
        vectors++;
        if (bus.dout !== (IRQ_ON ? 8'h02 : 8'h00)) begin
          miscompares++;
          $display("FAIL set_wins got %h exp %h", bus.dout, IRQ_ON ? 8'h02 : 8'h00);
        end
      end
      if (t == FT + 80 + 60 * HT) break;
      tick();
    end
  endtask

  task automatic test_midframe_reset();
    obs_t zero_obs, act, exp;
    int hs_first;
    zero_obs = '0;
    hs_first = -1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_bus(1'b1, 1'b1, 2'd2, 8'd0);
    @(negedge clk);
    act = dut_obs();
    vectors++;
    if (act !== zero_obs) begin
      miscompares++;
      $display("FAIL midreset_outputs got %h exp %h", act, zero_obs);
    end
    vectors++;
    if (bus.dout !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_frame got %h exp 00", bus.dout);
    end
    set_bus(1'b1, 1'b1, 2'd1, 8'd0);
    #1;
    vectors++;
    if (bus.dout !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_ctrl got %h exp 00", bus.dout);
    end
    release_reset();
    while (t < 2 * HT + 10) begin
      rand_read();
      @(negedge clk);
      act = dut_obs();
      exp = model_obs(t);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL restart t=%0d got %h exp %h", t, act, exp);
      end
      if (hs_first < 0 && hsync === 1'b1) hs_first = t;
      tick();
    end
    vectors++;
    if (hs_first != H_ACTIVE + H_FP) begin
      miscompares++;
      $display("FAIL restart_hsync got %0d exp %0d", hs_first, H_ACTIVE + H_FP);
    end
  endtask

  initial begin
    reset  = 1'b0;
    rgb_in = '0;
    set_bus(1'b0, 1'b1, 2'd0, 8'd0);
    test_reset();
    test_raster_frame();
    test_line_irq();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/video_timing.md
# video_timing

Raster timing generator and video output stage for the console display path. Drives the `hsync`/`vsync`/`hpos`/`vpos` raster inputs consumed by the chip's text buffer and sprite units, takes back their combined `rgb` after a fixed pipeline delay, and re-emits it blanked and aligned with delayed sync and data-enable for the display. Also exposes a small CPU-bus register window holding a raster-line interrupt, a frame counter and vblank status.

## Interface
- `H_ACTIVE`, 160: visible pixels per line; must be ≤ 256.
- `H_FP`, 8: horizontal front porch, in clocks.
- `H_SYNC`, 16: hsync width.
- `H_BP`, 16: horizontal back porch.
- `V_ACTIVE`, 120: visible lines; must be ≤ 128.
- `V_FP`, 3: vertical front porch, in lines.
- `V_SYNC`, 4: vsync width.
- `V_BP`, 13: vertical back porch.
- `PIPE`, 1: clocks from `hpos`/`vpos` to the matching `rgb_in`.
- `RGB`, 16: colour width.

- `clk` in 1: single clock, one pixel per cycle.
- `reset` in 1: synchronous, active-low.
- `hsync` out 1: active-high raster hsync to the chip.
- `vsync` out 1: active-high raster vsync to the chip.
- `hpos` out 8: `hcount[7:0]`.
- `vpos` out 7: `vcount[6:0]`.
- `rgb_in` in RGB: pixel colour from the chip.
- `vid_rgb` out RGB: blanked output colour.
- `vid_hs` out 1: output hsync.
- `vid_vs` out 1: output vsync.
- `vid_de` out 1: output data-enable.
- `cs` in 1: register select.
- `rw` in 1: 1 = read, 0 = write.
- `addr` in 2: register index.
- `di` in 8: write data.
- `dout` out 8: read data.
- `irq` out 1: raster interrupt, level, active-high.

## Operation
- Counters
  - `hcount` (9b) runs 0..HT-1, HT = H_ACTIVE+H_FP+H_SYNC+H_BP. Default HT = 200.
  - `vcount` (9b) increments when `hcount` wraps and runs 0..VT-1. Default VT = 140, so one frame is 28000 clocks.
- Sync decode
  - `hsync` = 1 when `hcount` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - `vsync` = 1 when `vcount` ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - `de` = (`hcount` < H_ACTIVE) && (`vcount` < V_ACTIVE).
  - All three are registered so they align with the counters.
- Output stage
  - `de`, `hsync` and `vsync` pass through a PIPE-deep shift register, then one output register.
  - `vid_rgb` = delayed `de` ? `rgb_in` : 0.
- Registers; writes take effect when `cs` && !`rw` at a clock edge.
  - 0 LINE: write sets `line_cmp`; read returns `vcount[7:0]`.
  - 1 CTRL: bit0 = `irq_en` (R/W); bit1 = `pending` (read; write 1 clears); bit2 = vblank (read-only, `vcount` ≥ V_ACTIVE). Other bits read as 0.
  - 2 FRAME: read-only 8-bit frame counter; increments as `vcount` wraps VT-1→0 and wraps 255→0.
  - 3: reads 0; writes are ignored.
  - `dout` is combinational. It is 0 when `cs` is low, so it can be ORed into the address decoder's read mux.
- Raster IRQ
  - On the cycle the counters move to `hcount`=0, `vcount`=N with N == `line_cmp`, `pending` is set.
  - `irq` = `pending` && `irq_en`.
  - Clearing `irq_en` masks `irq` but keeps `pending`.
  - A set and a write-1-clear in the same cycle: set wins.
  - A `line_cmp` ≥ VT never fires.

## Timing
- Reset (`reset`=0 at an edge):
  - `hcount`=`vcount`=0; `hsync`=`vsync`=0.
  - Pipeline, `vid_*`, `pending`, `irq_en`, FRAME and `irq` cleared to 0.
  - `line_cmp`=0.
  - Applies mid-frame or mid-line; the first cycle after release shows pixel (0,0).
- `hpos`/`vpos`/`hsync`/`vsync` for pixel (x,y) appear at cycle t = y·HT + x after reset release.
- `rgb_in` is sampled at t+PIPE; `vid_*` for that pixel are valid at t+PIPE+1.
- `irq` and `pending` rise in the same cycle `vpos` first shows the matching line.
- Register write results are visible on read in the next cycle.
- FRAME is visible one cycle after the (0,0) edge.

## Configuration
- `VIDEO_TIMING_RASTER_IRQ_EN`
  - Defined: LINE compare, `pending`, `irq_en` and `irq` are present as described.
  - Undefined: `irq` is tied to 0; CTRL bits 0–1 read 0 and writes to them are ignored; LINE reads still return `vcount[7:0]`; the compare logic is removed.

## Test plan
- Release `reset`, count clocks → `hsync` rises at cycle 168 and lasts 16 clocks; `vsync` first rises at cycle 123·200 = 24600 and lasts 800 clocks; FRAME reads 1 after cycle 28000.
- Drive `rgb_in` = {`hpos`, `vpos`} delayed by 1 → `vid_rgb` shows that pattern during `vid_de` and 0 outside it; `vid_de` is high for 160 clocks per line on 120 lines.
- Write LINE=50, CTRL=1 → `irq` rises at cycle 10000 with `vpos`=50; writing CTRL=0x03 in the set cycle of the next frame leaves `pending`=1.
- Write CTRL=0x02 outside a set cycle → `pending` and `irq` drop next cycle; with `irq_en`=0, `pending` still sets at line 50 while `irq` stays 0.
- Assert `reset` at x=80, y=60 with FRAME=3 and `pending` set → next cycle all outputs are 0 and FRAME reads 0; after release, timing restarts at (0,0).
- Build without `VIDEO_TIMING_RASTER_IRQ_EN`, repeat the LINE=50 case → `irq` stays 0 and CTRL reads 0x00 or 0x04.
